// File: rtl/serial_adder_fsm.sv
// rtl/serial_adder_fsm.sv - bit-serial WIDTH-bit adder with start/done handshake
// One full-adder cell processes one operand bit pair per clock, LSB first.
module serial_adder_fsm #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_carry;
    logic [CW-1:0]    r_count;

    logic             w_s;
    logic             w_c;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_next;

    assign w_s    = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
    assign w_c    = (r_a_sh[0] & r_b_sh[0]) | (r_b_sh[0] & r_carry) | (r_a_sh[0] & r_carry);
    assign w_last = (r_count == CW'(WIDTH - 1));

    // Written as shift-then-insert so WIDTH = 1 needs no special slicing.
    always_comb begin
        w_sum_next            = r_sum_sh >> 1;
        w_sum_next[WIDTH-1]   = w_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_count  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            S        <= '0;
            Cout     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a_sh  <= A;
                        r_b_sh  <= B;
                        r_carry <= Cin;
                        r_count <= '0;
                        busy    <= 1'b1;
                        r_state <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_sum_sh <= w_sum_next;
                    r_carry  <= w_c;
                    r_count  <= r_count + 1'b1;
                    // Results are published only on the completing edge.
                    if (w_last) begin
                        S       <= w_sum_next;
                        Cout    <= w_c;
                        done    <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_fsm.sv
// tb/tb_serial_adder_fsm.sv - self-checking bench for serial_adder_fsm (WIDTH=8 and WIDTH=1)
module tb_serial_adder_fsm;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         cout;

    logic         s1_start = 1'b0;
    logic         s1_a = 1'b0;
    logic         s1_b = 1'b0;
    logic         s1_cin = 1'b0;
    logic         s1_busy;
    logic         s1_done;
    logic         s1_s;
    logic         s1_cout;

    int n_cmp = 0;
    int n_err = 0;
    logic [W:0] last_res = '0;

    always #5 clk = ~clk;

    serial_adder_fsm #(.WIDTH(W)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b), .Cin(cin),
        .busy(busy), .done(done), .S(s), .Cout(cout)
    );

    serial_adder_fsm #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(s1_start), .A(s1_a), .B(s1_b), .Cin(s1_cin),
        .busy(s1_busy), .done(s1_done), .S(s1_s), .Cout(s1_cout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int unsigned t;
        t = int'(x) + int'(y) + int'(c);
        return t[W:0];
    endfunction

    // One full operation with cycle-by-cycle checks; noisy drives start and random operands during ADD.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input bit noisy);
        logic [W:0] exp_res;
        exp_res = ref_add(x, y, c);
        @(negedge clk);
        a = x; b = y; cin = c; start = 1'b1;
        @(posedge clk); #1;
        start = noisy;
        chk("accept_busy", busy, 1);
        chk("accept_done", done, 0);
        for (int k = 1; k <= W; k++) begin
            if (noisy) begin
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            end
            @(posedge clk); #1;
            chk("op_done_timing", done, (k == W));
            chk("op_busy", busy, 1);
            if (k < W) chk("op_hold_result", {cout, s}, last_res);
        end
        start = 1'b0;
        chk("op_result", {cout, s}, exp_res);
        last_res = exp_res;
        @(posedge clk); #1;
        chk("op_done_clear", done, 0);
        chk("op_busy_clear", busy, 0);
        @(posedge clk); #1;
        chk("no_extra_done", done, 0);
        chk("stays_idle", busy, 0);
    endtask

    initial begin
        logic [W-1:0] ca, cb;
        logic         cc;
        logic [W:0]   exp_res;
        int           lat;
        logic [2:0]   v;

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", {cout, s}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(8'h5A, 8'h3C, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b1, 1'b0);
        do_op(8'h5A, 8'h3C, 1'b0, 1'b1);

        // Asynchronous reset after three bits have been processed.
        @(negedge clk);
        a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_result", {cout, s}, 0);
        last_res = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 2) begin
            @(posedge clk); #1;
            chk("abandoned_no_done", done, 0);
        end
        do_op(8'h01, 8'h01, 1'b1, 1'b0);

        // Continuous start: back-to-back random operations.
        @(negedge clk);
        ca = W'($urandom); cb = W'($urandom); cc = 1'($urandom);
        a = ca; b = cb; cin = cc; start = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            chk("b2b_accept_busy", busy, 1);
            exp_res = ref_add(ca, cb, cc);
            ca = W'($urandom); cb = W'($urandom); cc = 1'($urandom);
            a = ca; b = cb; cin = cc;
            lat = 0;
            do begin
                @(posedge clk); #1;
                lat++;
            end while (!done && lat < W + 4);
            chk("b2b_latency", lat, W);
            chk("b2b_result", {cout, s}, exp_res);
            @(posedge clk); #1;
            chk("b2b_done_pulse", done, 0);
            chk("b2b_idle", busy, 0);
        end
        start = 1'b0;
        @(posedge clk); #1;
        chk("b2b_stop", busy, 0);

        // WIDTH=1 instance: full-adder truth table.
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            @(negedge clk);
            s1_a = v[2]; s1_b = v[1]; s1_cin = v[0]; s1_start = 1'b1;
            @(posedge clk); #1;
            s1_start = 1'b0;
            chk("w1_accept_done", s1_done, 0);
            chk("w1_accept_busy", s1_busy, 1);
            @(posedge clk); #1;
            chk("w1_done", s1_done, 1);
            chk("w1_result", {s1_cout, s1_s}, int'(v[2]) + int'(v[1]) + int'(v[0]));
            @(posedge clk); #1;
            chk("w1_done_clear", s1_done, 0);
            chk("w1_idle", s1_busy, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_adder_fsm.md
Name: serial_adder_fsm

Overview:
- Bit-serial WIDTH-bit adder built around a single 1-bit full-adder cell: sum = A ^ B ^ carry, carry-out = majority(A, B, carry).
- Consumes one operand bit pair per clock from internal shift registers, LSB first.
- Holds the carry in a flip-flop between bits.
- Sits downstream of the operand source and presents a registered WIDTH-bit sum plus carry-out with a start/done handshake.
- Used where area matters more than latency.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- A  input  WIDTH  operand A; captured on the accepted start edge
- B  input  WIDTH  operand B; captured on the accepted start edge
- Cin  input  1  carry-in; captured on the accepted start edge
- busy  output  1  high while in ADD or DONE
- done  output  1  one-cycle pulse when S/Cout update
- S  output  WIDTH  registered sum of the last completed operation
- Cout  output  1  registered carry-out of the last completed operation

Behaviour:
- Reset: rst_n low forces the following asynchronously, independent of clk:
  - state = IDLE; busy = 0; done = 0; S = 0; Cout = 0.
  - Internal shift registers, carry flip-flop and bit counter = 0.
  - Any operation in flight is abandoned; no done pulse is produced for it.
- Reset release: the first rising edge with rst_n high acts normally.
- States: IDLE, ADD, DONE.
- IDLE:
  - busy = 0.
  - On a rising edge with start = 1: load shift registers a_sh <= A and b_sh <= B; carry <= Cin; count <= 0; go to ADD.
  - On a rising edge with start = 0: stay in IDLE.
- ADD, on each rising edge:
  - s = a_sh[0] ^ b_sh[0] ^ carry.
  - c = (a_sh[0] & b_sh[0]) | (b_sh[0] & carry) | (a_sh[0] & carry).
  - Shift a_sh and b_sh right by 1.
  - Shift s into the MSB of the internal sum register (sum_sh).
  - carry <= c; count <= count + 1.
  - On the edge that processes bit WIDTH-1 (count == WIDTH-1): S <= final sum value, including that bit; Cout <= c; done <= 1; go to DONE.
- DONE:
  - Lasts exactly one cycle; done = 1 and busy = 1 during it.
  - Next edge: done <= 0; go to IDLE.
- Latency: start accepted at edge E; done high after edge E+WIDTH through edge E+WIDTH+1. Earliest next start is accepted at edge E+WIDTH+2. Throughput is one result per WIDTH+2 cycles.
- S and Cout change only on the completing edge and hold between operations. No intermediate values appear on them.
- start is ignored in ADD and DONE: no restart, no effect on the result.
- A, B and Cin may change freely after the accept edge.
- Arithmetic: {Cout, S} == A + B + Cin exactly, modulo 2^(WIDTH+1); no overflow flag.
- Counter width: clog2(WIDTH)+1 bits; no wrap-around is possible within one operation.
- WIDTH = 1: ADD lasts one edge; done follows the accept edge by 1.

Test Plan:
- WIDTH=8, A=0x5A, B=0x3C, Cin=0, start pulse -> done exactly 8 edges after accept; S=0x96, Cout=0; busy high for 9 cycles.
- A=0xFF, B=0x01, Cin=0 -> S=0x00, Cout=1. Then A=0xFF, B=0xFF, Cin=1 -> S=0xFF, Cout=1.
- During ADD, drive start=1 with A=0x00, B=0x00, and change A/B every cycle -> original result (S=0x96, Cout=0) unaffected; no extra done pulse.
- Assert rst_n=0 mid-ADD (after 3 bits), asynchronously between edges:
  - Immediately S=0, Cout=0, busy=0, done=0.
  - After release, start A=0x01, B=0x01, Cin=1 -> S=0x03, Cout=0.
- Hold start=1 continuously -> operations accepted every 10 cycles (WIDTH+2); each done is a single cycle; results match a reference model for 1000 random {A, B, Cin}.
- WIDTH=1 build, all 8 input combinations -> {Cout, S} equals the full-adder truth table; done 1 edge after accept.
